// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pkg : shared types and constants for the RV32I pipeline             |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory request/response bus                 |
// | Rev 1.0        : initial release                                         |
// +--------------------------------------------------------------------------+
interface fetch_stage_if
  import core_pkg::*;
();

  logic            req;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] rdata;
  logic            rvalid;

  modport master (output req, output addr, input rdata, input rvalid);
  modport slave  (input req, input addr, output rdata, output rvalid);

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register with kill/load/flush/stall priority  |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // A word arriving alongside flush still enters: flush targets the old content.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (kill) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (load) begin
      r_valid    <= 1'b1;
      r_instr    <= instr_in;
      r_pc       <= pc_in;
      r_pc_plus4 <= pc_in + XLEN'(4);
    end else if (flush || !stall) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

  assign instr_d    = r_instr;
  assign pc_d       = r_pc;
  assign pc_plus4_d = r_pc_plus4;
  assign valid_d    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : PC, fetch FSM and hold buffer feeding the IF/ID register   |
// | Rev 1.0     : initial release                                            |
// +--------------------------------------------------------------------------+
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   imem,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] r_hold_instr;

  logic            w_load;
  logic [XLEN-1:0] w_load_instr;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_unused_tgt_lsbs;

  assign imem.req          = (r_state == S_REQ) && !rst;
  assign imem.addr         = r_pc_f;
  assign w_redirect_pc     = {pc_target_e[XLEN-1:2], 2'b00};
  assign w_unused_tgt_lsbs = ^pc_target_e[1:0];

  assign w_load = !pc_src_e && !stall_d &&
                  (((r_state == S_WAIT) && imem.rvalid) || (r_state == S_HOLD));
  assign w_load_instr = (r_state == S_HOLD) ? r_hold_instr : imem.rdata;

  // The PC only advances when a word actually enters ID, so the hold buffer
  // never needs its own copy of the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc_f       <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
    end else if (pc_src_e) begin
      r_pc_f <= w_redirect_pc;
      case (r_state)
        S_REQ:   r_state <= S_DROP;
        S_WAIT:  r_state <= imem.rvalid ? S_REQ : S_DROP;
        S_HOLD:  r_state <= S_REQ;
        S_DROP:  r_state <= imem.rvalid ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem.rvalid) begin
            if (stall_d) begin
              r_hold_instr <= imem.rdata;
              r_state      <= S_HOLD;
            end else begin
              r_pc_f  <= r_pc_f + XLEN'(4);
              r_state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall_d) begin
            r_pc_f  <= r_pc_f + XLEN'(4);
            r_state <= S_REQ;
          end
        end
        S_DROP:  if (imem.rvalid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .kill       (pc_src_e),
    .flush      (flush_d),
    .stall      (stall_d),
    .load       (w_load),
    .instr_in   (w_load_instr),
    .pc_in      (r_pc_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

endmodule
`default_nettype wire
